ram_result_merger: RTL

RAM_RESULT_MERGER -- requirements
Module: ram_result_merger

---
 rtl/ram_result_merger_if.sv | 51 +++++
 rtl/ram_result_merger.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ram_result_merger_if.sv
// ram_result_merger_if
//   Bundles the even/odd read-port inputs, the write-port outputs and the
//   drain/status signals of ram_result_merger.
//   slave  : view used by the merger itself.
//   master : view used by whatever drives the merger (sources, sink, control).
//   Ports carried:
//     even_/odd_data_in [80:72] addr, [71:64] byte valid, [63:0] data
//     even_/odd_ram_select_in  nonzero means an entry is present
//     even_/odd_rd             pop strobe back to the source
//     wr_*                     registered output entry, wr_stall backpressure
//     block_out_finish/drain_done, busy, even_/odd_count
interface ram_result_merger_if #(
  parameter int CNT_W = 16
);
  logic [80:0]      even_data_in;
  logic [7:0]       even_ram_select_in;
  logic             even_rd;
  logic [80:0]      odd_data_in;
  logic [7:0]       odd_ram_select_in;
  logic             odd_rd;

  logic             wr_stall;
  logic             wr_valid;
  logic [63:0]      wr_data;
  logic [8:0]       wr_address;
  logic [7:0]       wr_byte_valid;
  logic [7:0]       wr_select;
  logic             wr_odd;

  logic             block_out_finish;
  logic             drain_done;
  logic             busy;
  logic [CNT_W-1:0] even_count;
  logic [CNT_W-1:0] odd_count;

  modport slave (
    input  even_data_in, even_ram_select_in, odd_data_in, odd_ram_select_in,
    input  wr_stall, block_out_finish,
    output even_rd, odd_rd,
    output wr_valid, wr_data, wr_address, wr_byte_valid, wr_select, wr_odd,
    output drain_done, busy, even_count, odd_count
  );

  modport master (
    output even_data_in, even_ram_select_in, odd_data_in, odd_ram_select_in,
    output wr_stall, block_out_finish,
    input  even_rd, odd_rd,
    input  wr_valid, wr_data, wr_address, wr_byte_valid, wr_select, wr_odd,
    input  drain_done, busy, even_count, odd_count
  );
endinterface

// File: rtl/ram_result_merger.sv
// ram_result_merger
//   Merges entries from an even and an odd read port into a single registered
//   write port. Ties are resolved round-robin, entries with zero byte valid are
//   popped and dropped, and a drain request waits for both ports and the output
//   register to empty before pulsing drain_done and clearing the counters.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous reset, active low
//     bus    ram_result_merger_if.slave (see interface file for the signal list)
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | nothing seen since the last drain; busy=0
//   ST_RUN   | forwarding entries; waiting for block_out_finish
//   ST_DRAIN | forwarding until both ports and the output register are empty
module ram_result_merger #(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_result_merger_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_odd_q, last_odd_d;
  logic             drain_done_q, drain_done_d;
  logic [CNT_W-1:0] even_cnt_q, even_cnt_d;
  logic [CNT_W-1:0] odd_cnt_q, odd_cnt_d;

  logic             wr_valid_q, wr_valid_d;
  logic [63:0]      wr_data_q, wr_data_d;
  logic [8:0]       wr_address_q, wr_address_d;
  logic [7:0]       wr_byte_valid_q, wr_byte_valid_d;
  logic [7:0]       wr_select_q, wr_select_d;
  logic             wr_odd_q, wr_odd_d;

  logic             even_pres;
  logic             odd_pres;
  logic             accept;
  logic             grant_even;
  logic             grant_odd;
  logic [80:0]      gnt_data;
  logic [7:0]       gnt_sel;
  logic             fwd;

  assign even_pres = |bus.even_ram_select_in;
  assign odd_pres  = |bus.odd_ram_select_in;
  assign accept    = ~wr_valid_q | ~bus.wr_stall;

  // rst_n gates the grants so no port is popped while reset is held, even
  // though the output register already reads empty.
  assign grant_even = rst_n & accept & even_pres & (~odd_pres | last_odd_q);
  assign grant_odd  = rst_n & accept & odd_pres  & (~even_pres | ~last_odd_q);

  assign gnt_data = grant_odd ? bus.odd_data_in       : bus.even_data_in;
  assign gnt_sel  = grant_odd ? bus.odd_ram_select_in : bus.even_ram_select_in;
  assign fwd      = (grant_even | grant_odd) & (|gnt_data[71:64]);

  always_comb begin
    last_odd_d      = last_odd_q;
    wr_valid_d      = wr_valid_q;
    wr_data_d       = wr_data_q;
    wr_address_d    = wr_address_q;
    wr_byte_valid_d = wr_byte_valid_q;
    wr_select_d     = wr_select_q;
    wr_odd_d        = wr_odd_q;

    if (grant_even | grant_odd) begin
      last_odd_d = grant_odd;
    end

    // Fields are only reloaded on a forwarded entry; a dropped entry or an
    // idle cycle just clears wr_valid and leaves the previous fields behind.
    if (accept) begin
      wr_valid_d = fwd;
      if (fwd) begin
        wr_address_d    = gnt_data[80:72];
        wr_byte_valid_d = gnt_data[71:64];
        wr_data_d       = gnt_data[63:0];
        wr_select_d     = gnt_sel;
        wr_odd_d        = grant_odd;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    even_cnt_d   = even_cnt_q;
    odd_cnt_d    = odd_cnt_q;

    if (fwd & grant_even) begin
      even_cnt_d = even_cnt_q + 1'b1;
    end
    if (fwd & grant_odd) begin
      odd_cnt_d = odd_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.block_out_finish) begin
          state_d = ST_DRAIN;
        end else if (even_pres | odd_pres) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.block_out_finish) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Ports empty means no grant this cycle, so clearing cannot race an
        // increment.
        if (~even_pres & ~odd_pres & ~wr_valid_q) begin
          state_d      = ST_IDLE;
          drain_done_d = 1'b1;
          even_cnt_d   = '0;
          odd_cnt_d    = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      last_odd_q      <= 1'b1;
      drain_done_q    <= 1'b0;
      even_cnt_q      <= '0;
      odd_cnt_q       <= '0;
      wr_valid_q      <= 1'b0;
      wr_data_q       <= '0;
      wr_address_q    <= '0;
      wr_byte_valid_q <= '0;
      wr_select_q     <= '0;
      wr_odd_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_odd_q      <= last_odd_d;
      drain_done_q    <= drain_done_d;
      even_cnt_q      <= even_cnt_d;
      odd_cnt_q       <= odd_cnt_d;
      wr_valid_q      <= wr_valid_d;
      wr_data_q       <= wr_data_d;
      wr_address_q    <= wr_address_d;
      wr_byte_valid_q <= wr_byte_valid_d;
      wr_select_q     <= wr_select_d;
      wr_odd_q        <= wr_odd_d;
    end
  end

  assign bus.even_rd       = grant_even;
  assign bus.odd_rd        = grant_odd;
  assign bus.wr_valid      = wr_valid_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.wr_address    = wr_address_q;
  assign bus.wr_byte_valid = wr_byte_valid_q;
  assign bus.wr_select     = wr_select_q;
  assign bus.wr_odd        = wr_odd_q;
  assign bus.drain_done    = drain_done_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.even_count    = even_cnt_q;
  assign bus.odd_count     = odd_cnt_q;

endmodule
